mem_responder_512x32: RTL and testbench
=======================================

// Module: mem_responder_512x32
// PURPOSE
//  Memory-side responder for the datapath memory interface: answers Mem_Read/Mem_Write
//  requests issued by the control sequence (address from MAR, write data from MDR)
//  with a configurable-latency single-port RAM and a one-cycle memory_done pulse.
//  Sits between System's MAR/MDR and the 512x32 store. Also provides the override
//  preload port used to place programs and data in memory before execution.
// PARAMETERS
//  DATA_WIDTH     32  word width
//  ADDR_WIDTH     9   address width; depth = 2**ADDR_WIDTH (512)
//  READ_LATENCY   1   edges from read acceptance to data/done (legal 1..15)
//  WRITE_LATENCY  1   edges from write acceptance to commit/done (legal 1..15)
// PORTS
//  Clock             in   1    rising-edge clock
//  clear             in   1    synchronous reset, ACTIVE-LOW (0 = reset)
//  Mem_enable512x32  in   1    request strobe, sampled on rising edge
//  Mem_Read          in   1    read request qualifier
//  Mem_Write         in   1    write request qualifier
//  MAR_address       in   AW   request address
//  Mem_data_to_chip  in   DW   write data (from MDR)
//  mem_overide       in   1    preload mode; aborts/blocks datapath traffic
//  overide_address   in   AW   preload address
//  overide_data_in   in   DW   preload data
//  Mem_to_datapath   out  DW   read data (to MDR), registered
//  memory_done       out  1    one-cycle completion pulse
//  mem_busy          out  1    1 while a transaction is in flight (state != IDLE)
//  err_illegal       out  1    one-cycle pulse: Read and Write both set at acceptance
// BEHAVIOUR
//  - Reset (clear==0 at edge): state=IDLE, counter=0, Mem_to_datapath=0, memory_done=0,
//    mem_busy=0, err_illegal=0. RAM contents NOT cleared. Reset wins over all inputs.
//  - FSM: IDLE, BUSY, DONE. Latched at acceptance: op, address, write data.
//  - IDLE: at edge E0 with mem_overide=0, Mem_enable512x32=1:
//      Read xor Write -> BUSY, cnt=LAT-1 (LAT per op); neither -> stay IDLE;
//      both -> stay IDLE, err_illegal=1 for one cycle, nothing accessed.
//  - BUSY: each edge cnt==0 -> DONE, else cnt--. Transition edge is E0+LAT:
//      read: Mem_to_datapath <= RAM[addr_latched]; write: RAM[addr_latched] <= data_latched;
//      memory_done=1 registered at same edge (high for exactly cycle E0+LAT..E0+LAT+1).
//  - DONE: next edge -> IDLE unconditionally; memory_done falls. Requests seen
//    in BUSY or DONE are ignored (no queueing). Earliest next acceptance: E0+LAT+2.
//  - Mem_to_datapath holds last read value; writes never change it.
//  - Read data reflects RAM at the commit edge, not at acceptance.
//  - Override: mem_overide=1 at an edge forces state=IDLE, cnt=0, no done, no commit
//    of any in-flight write (abort). If also Mem_enable512x32=1:
//    RAM[overide_address] <= overide_data_in that edge; no memory_done, no err_illegal.
//  - Reset mid-BUSY: transaction aborted, pending write NOT committed, no done pulse.
//  - Addresses are exactly ADDR_WIDTH bits; no wrap logic needed; 0 and 511 fully valid.
//  - All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  1 clear=0 for 2 edges -> memory_done=0, mem_busy=0, err_illegal=0, Mem_to_datapath=0.
//  2 Override write addr 0 = 32'h0807FFFF, then read addr 0 (RL=1) accepted at E0 ->
//    memory_done=1 and Mem_to_datapath=32'h0807FFFF at E0+1, done=0 at E0+2.
//  3 RL=WL=3: write 32'h00000014 to addr 500 at E0 -> done at E0+3; read 500 at E0+5
//    -> done and data 32'h00000014 at E0+8; mem_busy high E0+5..E0+8.
//  4 Read=Write=1 with enable at addr 1 -> err_illegal pulse 1 cycle, no done,
//    subsequent read of addr 1 returns prior contents.
//  5 Write 32'hDEADBEEF to 511 (WL=3), assert clear=0 at E0+1 -> no done; read 511
//    returns old value. Repeat with mem_overide=1 at E0+1 instead -> same result.
//  6 Second request issued at E0+1 during BUSY -> ignored: exactly one done pulse,
//    Mem_to_datapath unchanged by the ignored request.

Source files
------------

// File: rtl/mem_responder_512x32.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_512x32
//  Description : Memory-side responder for the datapath memory interface.
//                Accepts MAR/MDR read or write requests, services them from a
//                single-port RAM after a fixed per-operation latency and
//                signals completion with a one-cycle memory_done pulse.
//                A preload (override) port writes the RAM directly and
//                aborts any in-flight datapath transaction.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_responder_512x32 #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 9,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  Mem_enable512x32,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic [ADDR_WIDTH-1:0] MAR_address,
    input  logic [DATA_WIDTH-1:0] Mem_data_to_chip,
    input  logic                  mem_overide,
    input  logic [ADDR_WIDTH-1:0] overide_address,
    input  logic [DATA_WIDTH-1:0] overide_data_in,
    output logic [DATA_WIDTH-1:0] Mem_to_datapath,
    output logic                  memory_done,
    output logic                  mem_busy,
    output logic                  err_illegal
);

    localparam int         c_DEPTH   = 1 << ADDR_WIDTH;
    // Counter preload values: the transaction completes LAT edges after acceptance.
    localparam logic [3:0] c_RD_CNT  = 4'(READ_LATENCY - 1);
    localparam logic [3:0] c_WR_CNT  = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_op_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    logic                  w_accept;
    logic                  w_legal;
    logic                  w_commit;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;

    // Request qualification and the single RAM write port shared by preload and datapath.
    always_comb begin
        w_accept    = clear && !mem_overide && (r_state == ST_IDLE) && Mem_enable512x32;
        w_legal     = Mem_Read ^ Mem_Write;
        // Completion edge of an in-flight transaction; reset and override both abort it.
        w_commit    = clear && !mem_overide && (r_state == ST_BUSY) && (r_cnt == 4'd0);
        w_ram_we    = 1'b0;
        w_ram_addr  = r_addr;
        w_ram_wdata = r_wdata;
        if (clear && mem_overide) begin
            w_ram_we    = Mem_enable512x32;
            w_ram_addr  = overide_address;
            w_ram_wdata = overide_data_in;
        end else if (w_commit && r_op_write) begin
            w_ram_we    = 1'b1;
        end
    end

    // RAM array: no reset so contents survive clear and the store maps onto block RAM.
    always_ff @(posedge Clock) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
    end

    // Transaction FSM with registered done/busy/error/read-data outputs.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            r_state         <= ST_IDLE;
            r_cnt           <= 4'd0;
            r_op_write      <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            Mem_to_datapath <= '0;
            memory_done     <= 1'b0;
            mem_busy        <= 1'b0;
            err_illegal     <= 1'b0;
        end else if (mem_overide) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            memory_done <= 1'b0;
            mem_busy    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    memory_done <= 1'b0;
                    err_illegal <= 1'b0;
                    if (w_accept) begin
                        if (w_legal) begin
                            r_state    <= ST_BUSY;
                            r_cnt      <= Mem_Read ? c_RD_CNT : c_WR_CNT;
                            r_op_write <= Mem_Write;
                            r_addr     <= MAR_address;
                            r_wdata    <= Mem_data_to_chip;
                            mem_busy   <= 1'b1;
                        end else if (Mem_Read && Mem_Write) begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_DONE;
                        memory_done <= 1'b1;
                        // Read samples the array at completion so late writes are visible.
                        if (!r_op_write) begin
                            Mem_to_datapath <= r_mem[r_addr];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    memory_done <= 1'b0;
                    mem_busy    <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    memory_done <= 1'b0;
                    mem_busy    <= 1'b0;
                    err_illegal <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder_512x32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder_512x32
//  Description : Self-checking bench for mem_responder_512x32. Two instances:
//                A with 1-cycle latencies, B with 3-cycle latencies. Requests
//                push expected completions to per-instance queues; a monitor
//                pops and compares them when memory_done is observed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_responder_512x32;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          done_cyc;
    } exp_t;

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        Mem_Read = 1'b0, Mem_Write = 1'b0;
    logic [8:0]  MAR_address = '0;
    logic [31:0] Mem_data_to_chip = '0;
    logic        mem_overide = 1'b0;
    logic [8:0]  overide_address = '0;
    logic [31:0] overide_data_in = '0;

    logic [31:0] rd_a, rd_b;
    logic        done_a, done_b, busy_a, busy_b, err_a, err_b;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];

    mem_responder_512x32 #(.READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut_a (
        .Clock(Clock), .clear(clear), .Mem_enable512x32(en_a),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .MAR_address(MAR_address),
        .Mem_data_to_chip(Mem_data_to_chip), .mem_overide(mem_overide),
        .overide_address(overide_address), .overide_data_in(overide_data_in),
        .Mem_to_datapath(rd_a), .memory_done(done_a), .mem_busy(busy_a),
        .err_illegal(err_a)
    );

    mem_responder_512x32 #(.READ_LATENCY(3), .WRITE_LATENCY(3)) u_dut_b (
        .Clock(Clock), .clear(clear), .Mem_enable512x32(en_b),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .MAR_address(MAR_address),
        .Mem_data_to_chip(Mem_data_to_chip), .mem_overide(mem_overide),
        .overide_address(overide_address), .overide_data_in(overide_data_in),
        .Mem_to_datapath(rd_b), .memory_done(done_b), .mem_busy(busy_b),
        .err_illegal(err_b)
    );

    always #5 Clock = ~Clock;

    // After edge k, cyc == k.
    always @(posedge Clock) cyc <= cyc + 1;

    // Scoreboard monitor: runs 1 time unit after each edge, ahead of the tasks.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (done_a) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done_a cyc=%0d got done=1 want done=0", cyc);
                end else begin
                    e = q_a.pop_front();
                    if (cyc !== e.done_cyc) begin
                        errors++;
                        $display("FAIL done_time_a got cyc=%0d want cyc=%0d", cyc, e.done_cyc);
                    end
                    if (e.is_read) begin
                        checks++;
                        if (rd_a !== e.data) begin
                            errors++;
                            $display("FAIL read_data_a got %h want %h", rd_a, e.data);
                        end
                    end
                end
            end else if (q_a.size() > 0 && q_a[0].done_cyc == cyc) begin
                checks++;
                errors++;
                e = q_a.pop_front();
                $display("FAIL missing_done_a cyc=%0d got done=0 want done=1", cyc);
            end
            if (done_b) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done_b cyc=%0d got done=1 want done=0", cyc);
                end else begin
                    e = q_b.pop_front();
                    if (cyc !== e.done_cyc) begin
                        errors++;
                        $display("FAIL done_time_b got cyc=%0d want cyc=%0d", cyc, e.done_cyc);
                    end
                    if (e.is_read) begin
                        checks++;
                        if (rd_b !== e.data) begin
                            errors++;
                            $display("FAIL read_data_b got %h want %h", rd_b, e.data);
                        end
                    end
                end
            end else if (q_b.size() > 0 && q_b[0].done_cyc == cyc) begin
                checks++;
                errors++;
                e = q_b.pop_front();
                $display("FAIL missing_done_b cyc=%0d got done=0 want done=1", cyc);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    // Drive one request for a single cycle; returns just after the acceptance edge E0.
    task automatic issue(input int sel, input bit rd, input bit wr,
                         input logic [8:0] addr, input logic [31:0] data, input bit track);
        exp_t e;
        Mem_Read         = rd;
        Mem_Write        = wr;
        MAR_address      = addr;
        Mem_data_to_chip = data;
        if (sel == 0) en_a = 1'b1; else en_b = 1'b1;
        if (track && (rd ^ wr)) begin
            e.is_read  = rd;
            e.done_cyc = cyc + 1 + ((sel == 0) ? 1 : 3);
            e.data     = data;
            if (sel == 0) begin
                if (rd) e.data = mdl_a[int'(addr)]; else mdl_a[int'(addr)] = data;
                q_a.push_back(e);
            end else begin
                if (rd) e.data = mdl_b[int'(addr)]; else mdl_b[int'(addr)] = data;
                q_b.push_back(e);
            end
        end
        tick();
        en_a = 1'b0; en_b = 1'b0; Mem_Read = 1'b0; Mem_Write = 1'b0;
    endtask

    task automatic preload(input int sel, input logic [8:0] addr, input logic [31:0] data);
        mem_overide     = 1'b1;
        overide_address = addr;
        overide_data_in = data;
        if (sel == 0) begin en_a = 1'b1; mdl_a[int'(addr)] = data; end
        else          begin en_b = 1'b1; mdl_b[int'(addr)] = data; end
        tick();
        mem_overide = 1'b0; en_a = 1'b0; en_b = 1'b0;
    endtask

    // Bounded wait until all tracked completions are observed and both units idle.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL drain_%s got pending=%0d/%0d want 0/0", name, q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        tick();
        tick();
        checks += 8;
        if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b want 0", done_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
        if (err_a  !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b want 0", err_a); end
        if (rd_a   !== 32'h0) begin errors++; $display("FAIL reset_data_a got %h want 0", rd_a); end
        if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b got %b want 0", done_b); end
        if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
        if (err_b  !== 1'b0) begin errors++; $display("FAIL reset_err_b got %b want 0", err_b); end
        if (rd_b   !== 32'h0) begin errors++; $display("FAIL reset_data_b got %h want 0", rd_b); end
        clear = 1'b1;
        tick();
    endtask

    task automatic test_override_read();
        preload(0, 9'd0, 32'h0807FFFF);
        checks += 2;
        if (err_a !== 1'b0)  begin errors++; $display("FAIL preload_err got %b want 0", err_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL preload_busy got %b want 0", busy_a); end
        issue(0, 1'b1, 1'b0, 9'd0, 32'h0, 1'b1);
        tick();
        tick();
        checks += 2;
        if (done_a !== 1'b0) begin errors++; $display("FAIL rl1_done_fall got %b want 0", done_a); end
        if (rd_a !== 32'h0807FFFF) begin errors++; $display("FAIL rl1_data_hold got %h want 0807ffff", rd_a); end
        wait_drain("override_read");
    endtask

    task automatic test_latency3();
        issue(1, 1'b0, 1'b1, 9'd500, 32'h00000014, 1'b1);
        tick(); tick(); tick(); tick();
        issue(1, 1'b1, 1'b0, 9'd500, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy_b !== 1'b1) begin errors++; $display("FAIL busy_b_rd+%0d got %b want 1", i, busy_b); end
            tick();
        end
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL busy_b_end got %b want 0", busy_b); end
        wait_drain("latency3");
    endtask

    task automatic test_illegal();
        preload(0, 9'd1, 32'h11111111);
        issue(0, 1'b1, 1'b1, 9'd1, 32'h00000BAD, 1'b1);
        checks += 2;
        if (err_a !== 1'b1)  begin errors++; $display("FAIL illegal_err got %b want 1", err_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL illegal_busy got %b want 0", busy_a); end
        tick();
        checks++;
        if (err_a !== 1'b0) begin errors++; $display("FAIL illegal_err_fall got %b want 0", err_a); end
        issue(0, 1'b1, 1'b0, 9'd1, 32'h0, 1'b1);
        wait_drain("illegal");
    endtask

    task automatic test_abort();
        preload(1, 9'd511, 32'hCAFEF00D);
        issue(1, 1'b0, 1'b1, 9'd511, 32'hDEADBEEF, 1'b0);
        clear = 1'b0;
        tick();
        clear = 1'b1;
        checks += 2;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL abort_rst_busy got %b want 0", busy_b); end
        if (rd_b !== 32'h0)  begin errors++; $display("FAIL abort_rst_data got %h want 0", rd_b); end
        tick(); tick(); tick(); tick();
        issue(1, 1'b1, 1'b0, 9'd511, 32'h0, 1'b1);
        wait_drain("abort_reset");
        issue(1, 1'b0, 1'b1, 9'd511, 32'hDEADBEEF, 1'b0);
        mem_overide = 1'b1;
        tick();
        mem_overide = 1'b0;
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL abort_ovr_busy got %b want 0", busy_b); end
        tick(); tick(); tick(); tick();
        issue(1, 1'b1, 1'b0, 9'd511, 32'h0, 1'b1);
        wait_drain("abort_override");
    endtask

    task automatic test_ignored_request();
        issue(1, 1'b1, 1'b0, 9'd500, 32'h0, 1'b1);
        Mem_Read    = 1'b1;
        MAR_address = 9'd511;
        en_b        = 1'b1;
        tick();
        tick();
        en_b = 1'b0; Mem_Read = 1'b0;
        wait_drain("ignored");
        tick(); tick();
        checks++;
        if (rd_b !== 32'h00000014) begin errors++; $display("FAIL ignored_data got %h want 00000014", rd_b); end
    endtask

    task automatic test_back_to_back();
        issue(0, 1'b0, 1'b1, 9'd511, 32'hA5A5_0001, 1'b1);
        tick(); tick();
        issue(0, 1'b1, 1'b0, 9'd511, 32'h0, 1'b1);
        tick(); tick();
        issue(0, 1'b0, 1'b1, 9'd0, 32'h1234_5678, 1'b1);
        tick(); tick();
        issue(0, 1'b1, 1'b0, 9'd0, 32'h0, 1'b1);
        tick(); tick();
        issue(0, 1'b1, 1'b0, 9'd511, 32'h0, 1'b1);
        wait_drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_override_read();
        test_latency3();
        test_illegal();
        test_abort();
        test_ignored_request();
        test_back_to_back();
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
